// File: rtl/mem_arbiter_pkg.sv
// Shared types for the instruction/data memory arbiter.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        DM_BUSY = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_IF   = 2'd1,
        GNT_DM   = 2'd2
    } gnt_e;

    // Bits needed to hold a counter that reaches max_val.
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-bus signals of the arbiter. The master view is the
// arbiter itself; the slave view is the CPU stages plus the memory model.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int BE_W = DATA_W / 8;

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ack;

    logic              dm_req;
    logic              dm_we;
    logic [BE_W-1:0]   dm_be;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_ack;

    logic              mem_req;
    logic              mem_we;
    logic [BE_W-1:0]   mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;
    logic              bus_err;

    modport master (
        input  if_req, if_addr,
        output if_rdata, if_ack,
        input  dm_req, dm_we, dm_be, dm_addr, dm_wdata,
        output dm_rdata, dm_ack,
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready,
        output bus_err
    );

    modport slave (
        output if_req, if_addr,
        input  if_rdata, if_ack,
        output dm_req, dm_we, dm_be, dm_addr, dm_wdata,
        input  dm_rdata, dm_ack,
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_rdata, mem_ready,
        input  bus_err
    );

endinterface

// File: rtl/mem_arbiter_grant.sv
// Combinational grant decision: data port has priority unless the fetch port
// has already been passed over STARVE_MAX times in a row.
module mem_arbiter_grant
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 2,
    parameter int SW         = cnt_w(STARVE_MAX)
) (
    input  logic          if_req,
    input  logic          dm_req,
    input  logic [SW-1:0] starve_cnt,
    output gnt_e          gnt
);

    // Priority select with the starvation override for the fetch port.
    always_comb begin
        gnt = GNT_NONE;
        if (dm_req && !(if_req && (starve_cnt == SW'(STARVE_MAX))))
            gnt = GNT_DM;
        else if (if_req)
            gnt = GNT_IF;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one variable-latency memory bus between the fetch and data ports.
// One transaction in flight at a time; registered acks, read data and
// timeout abort with bus_err.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int TIMEOUT    = 15,
    parameter int STARVE_MAX = 2
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.master bus
);

    localparam int BE_W = DATA_W / 8;
    localparam int TW   = cnt_w(TIMEOUT);
    localparam int SW   = cnt_w(STARVE_MAX);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    state_e            state, state_nxt;
    gnt_e              gnt;
    logic              if_m, dm_m;
    logic              busy, done, abort, granted;
    logic [SW-1:0]     starve_cnt;
    logic [TW-1:0]     tmo_cnt;

    logic              lat_req;
    logic              lat_we;
    logic [BE_W-1:0]   lat_be;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;

    // A request acked this cycle is still high but already served.
    assign if_m    = bus.if_req & ~bus.if_ack;
    assign dm_m    = bus.dm_req & ~bus.dm_ack;
    assign busy    = (state != IDLE);
    assign done    = busy & bus.mem_ready;
    // Abort when this idle-bus cycle would bring the count to TIMEOUT.
    assign abort   = busy & ~bus.mem_ready & (tmo_cnt == TMO_LAST);
    assign granted = (state == IDLE) & (gnt != GNT_NONE);

    mem_arbiter_grant #(.STARVE_MAX(STARVE_MAX), .SW(SW)) u_grant (
        .if_req     (if_m),
        .dm_req     (dm_m),
        .starve_cnt (starve_cnt),
        .gnt        (gnt)
    );

    assign bus.mem_req   = lat_req;
    assign bus.mem_we    = lat_we;
    assign bus.mem_be    = lat_be;
    assign bus.mem_addr  = lat_addr;
    assign bus.mem_wdata = lat_wdata;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state: grant from IDLE, return on completion or abort.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (gnt == GNT_IF)      state_nxt = IF_BUSY;
                else if (gnt == GNT_DM) state_nxt = DM_BUSY;
            end
            IF_BUSY, DM_BUSY: begin
                if (done || abort) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Starvation count: DM wins while IF waits; any IF grant or idle IF clears.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            starve_cnt <= '0;
        else if (!if_m || (granted && gnt == GNT_IF))
            starve_cnt <= '0;
        else if (granted && gnt == GNT_DM)
            starve_cnt <= starve_cnt + SW'(1);
    end

    // Timeout count of busy cycles without mem_ready.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                    tmo_cnt <= '0;
        else if (granted)              tmo_cnt <= '0;
        else if (busy && !bus.mem_ready) tmo_cnt <= tmo_cnt + TW'(1);
    end

    // Latch the granted request; it drives the bus until completion.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lat_req   <= 1'b0;
            lat_we    <= 1'b0;
            lat_be    <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if (granted) begin
            lat_req <= 1'b1;
            if (gnt == GNT_IF) begin
                lat_we    <= 1'b0;
                lat_be    <= '1;
                lat_addr  <= bus.if_addr;
                lat_wdata <= '0;
            end else begin
                lat_we    <= bus.dm_we;
                lat_be    <= bus.dm_be;
                lat_addr  <= bus.dm_addr;
                lat_wdata <= bus.dm_wdata;
            end
        end else if (done || abort) begin
            lat_req <= 1'b0;
        end
    end

    // Response side: one-cycle acks, read data capture, zero data on abort.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.if_ack   <= 1'b0;
            bus.dm_ack   <= 1'b0;
            bus.bus_err  <= 1'b0;
            bus.if_rdata <= '0;
            bus.dm_rdata <= '0;
        end else begin
            bus.if_ack  <= (state == IF_BUSY) & (done | abort);
            bus.dm_ack  <= (state == DM_BUSY) & (done | abort);
            bus.bus_err <= abort;
            if (state == IF_BUSY) begin
                if (done)       bus.if_rdata <= bus.mem_rdata;
                else if (abort) bus.if_rdata <= '0;
            end
            if (state == DM_BUSY) begin
                if (done && !lat_we) bus.dm_rdata <= bus.mem_rdata;
                else if (abort)      bus.dm_rdata <= '0;
            end
        end
    end

endmodule
